// File: rtl/hazard_flush_ctrl_if.sv
// Bundle between the decode-side hazard/flush controller and the pipeline
// stage registers it steers. The master drives the hazard inputs and receives
// the write-enable/flush controls; the slave is the controller itself.
interface hazard_flush_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              ifid_valid;
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              idex_memread;
  logic [REG_AW-1:0] idex_rd;
  logic              exmem_branch_taken;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output ifid_valid, ifid_rs1, ifid_rs2, idex_memread, idex_rd, exmem_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_count, flush_count
  );

  modport slave (
    input  ifid_valid, ifid_rs1, ifid_rs2, idex_memread, idex_rd, exmem_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Load-use hazard and taken-branch flush controller for a 5-stage pipeline.
// Outputs are Mealy (same-cycle) so the stage registers act on the next edge.
// A taken branch in MEM always wins over a load-use stall and cancels any
// bubbles still pending. Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_flush_ctrl #(
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_flush_ctrl_if.slave bus
);

  // Remaining-bubble counter only needs to hold STALL_CYCLES-1.
  localparam int            RW       = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [RW-1:0] REM_INIT = RW'(STALL_CYCLES - 1);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_remaining;
  logic [RW-1:0]   w_remaining_nxt;
  logic            w_hazard;
  logic            w_pc_write;
  logic            w_ifid_write;
  logic            w_ifid_flush;
  logic            w_idex_flush;
  logic            w_exmem_flush;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_hazard = bus.ifid_valid & bus.idex_memread &
                    (bus.idex_rd != {REG_AW{1'b0}}) &
                    ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));

  // State and remaining-bubble register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= {RW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state and Mealy control outputs; reset forces a full flush with PC frozen.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_ifid_flush    = 1'b0;
    w_idex_flush    = 1'b0;
    w_exmem_flush   = 1'b0;
    if (reset) begin
      w_pc_write      = 1'b0;
      w_ifid_write    = 1'b0;
      w_ifid_flush    = 1'b1;
      w_idex_flush    = 1'b1;
      w_exmem_flush   = 1'b1;
      w_state_nxt     = IDLE;
      w_remaining_nxt = {RW{1'b0}};
    end else if (bus.exmem_branch_taken) begin
      w_ifid_flush    = 1'b1;
      w_idex_flush    = 1'b1;
      w_exmem_flush   = 1'b1;
      w_state_nxt     = IDLE;
      w_remaining_nxt = {RW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hazard) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            if (STALL_CYCLES > 1) begin
              w_state_nxt     = STALL;
              w_remaining_nxt = REM_INIT;
            end else begin
              w_state_nxt     = IDLE;
              w_remaining_nxt = {RW{1'b0}};
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        STALL: begin
          // Hazard input is ignored here: the bubble train is already committed.
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          if (r_remaining <= REM_ONE) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = {RW{1'b0}};
          end else begin
            w_state_nxt     = STALL;
            w_remaining_nxt = r_remaining - REM_ONE;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = {RW{1'b0}};
        end
      endcase
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_flush = w_exmem_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_cyc;

  // PC is frozen only by a stall once out of reset (reset holds the counters).
  assign w_stall_cyc = ~w_pc_write;

  // Saturating performance counters for stall cycles and taken-branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_stall_cyc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (bus.exmem_branch_taken && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
  assign bus.flush_count = {CNT_W{1'b0}};
`endif

endmodule
